bitserial_deser: RTL

BITSERIAL_DESER -- requirements
Module: bitserial_deser

---
 rtl/bitserial_pkg.sv | 9 +
 rtl/bitserial_deser_if.sv | 33 +++
 rtl/bitserial_deser_outbuf.sv | 40 ++++
 rtl/bitserial_deser.sv | 70 +++++++
 4 files changed

// File: rtl/bitserial_pkg.sv
// bitserial_pkg: shared FSM state type, default width and counter sizing
// for the bit-serial deserializer.
package bitserial_pkg;
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam int BITSERIAL_W = 8;
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/bitserial_deser_if.sv
// bitserial_deser_if: serial input side plus parallel valid/ready output side.
// BITSERIAL_DESER_CARRY_EN adds s_carry and widens m_data by one bit.
interface bitserial_deser_if import bitserial_pkg::*; #(parameter int W = BITSERIAL_W);
`ifdef BITSERIAL_DESER_CARRY_EN
    localparam int DW = W + 1;
    logic s_carry;
`else
    localparam int DW = W;
`endif
    logic s_bit;
    logic s_valid;
    logic s_first;
    logic [DW-1:0] m_data;
    logic m_valid;
    logic m_ready;
    logic overrun;
    logic frame_err;
    logic busy;
    modport master (
`ifdef BITSERIAL_DESER_CARRY_EN
        output s_carry,
`endif
        output s_bit, s_valid, s_first, m_ready,
        input  m_data, m_valid, overrun, frame_err, busy
    );
    modport slave (
`ifdef BITSERIAL_DESER_CARRY_EN
        input  s_carry,
`endif
        input  s_bit, s_valid, s_first, m_ready,
        output m_data, m_valid, overrun, frame_err, busy
    );
endinterface

// File: rtl/bitserial_deser_outbuf.sv
// bitserial_deser_outbuf: one-word holding register with valid/ready handshake;
// a word completing while the held word is stalled is dropped and flagged.
module bitserial_deser_outbuf #(parameter int DW = 8) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [DW-1:0] i_word,
    input  logic          i_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    output logic          o_overrun
);
    logic [DW-1:0] r_data;
    logic          r_valid;
    logic          r_overrun;
    logic          w_free;

    // the slot is free if empty or being drained on this same edge
    assign w_free = !r_valid || i_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_load && !w_free;
            if (i_load && w_free) begin
                r_data  <= i_word;
                r_valid <= 1'b1;
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
endmodule

// File: rtl/bitserial_deser.sv
// bitserial_deser: LSB-first serial-to-parallel converter with s_first resync.
// Optional carry bit on m_data[W] when BITSERIAL_DESER_CARRY_EN is defined.
module bitserial_deser import bitserial_pkg::*; #(parameter int W = BITSERIAL_W) (
    input logic clk,
    input logic reset,
    bitserial_deser_if.slave bus
);
    localparam int CW = cnt_width(W);
`ifdef BITSERIAL_DESER_CARRY_EN
    localparam int DW = W + 1;
`else
    localparam int DW = W;
`endif

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [W-2:0]  r_shift;
    logic          r_frame_err;
    logic          w_last;
    logic          w_done;
    logic [DW-1:0] w_word;

    assign w_last = r_cnt == CW'(W - 1);
    assign w_done = r_state == SHIFT && bus.s_valid && !bus.s_first && w_last;
    // the final bit bypasses the shift register straight into the output stage
`ifdef BITSERIAL_DESER_CARRY_EN
    assign w_word = {bus.s_carry, bus.s_bit, r_shift};
`else
    assign w_word = {bus.s_bit, r_shift};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            if (bus.s_valid && bus.s_first) begin
                r_frame_err <= r_state == SHIFT;
                r_state     <= SHIFT;
                r_cnt       <= CW'(1);
                r_shift     <= (W-1)'(bus.s_bit);
            end else if (bus.s_valid && r_state == SHIFT) begin
                if (w_last) begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_shift[r_cnt] <= bus.s_bit;
                    r_cnt          <= r_cnt + CW'(1);
                end
            end
        end
    end

    bitserial_deser_outbuf #(.DW(DW)) u_outbuf (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_done),
        .i_word    (w_word),
        .i_ready   (bus.m_ready),
        .o_data    (bus.m_data),
        .o_valid   (bus.m_valid),
        .o_overrun (bus.overrun)
    );

    assign bus.frame_err = r_frame_err;
    assign bus.busy      = r_state == SHIFT;
endmodule
